// File: rtl/mips_pkg.sv
// mips_pkg: controller states, opcode/funct values, ALU codes and datapath mux encodings
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXEC,
        S_ALUWB, S_BRANCH, S_IMMEXEC, S_IMMWB, S_JUMP, S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ZX_SIGN = 2'b00;
    localparam logic [1:0] ZX_ZERO = 2'b01;

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps op/funct to the 3-bit ALU code and flags undefined opcodes and functs
module mips_alu_decoder
    import mips_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [2:0]         alu,
    output logic               bad_op,
    output logic               bad_funct
);

    logic [2:0] fcode;

    always_comb begin
        fcode = funct == F_ADD ? ALU_ADD :
                funct == F_SUB ? ALU_SUB :
                funct == F_OR  ? ALU_OR  :
                funct == F_SLT ? ALU_SLT : ALU_AND;
        bad_funct = !(funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
        bad_op = !(op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW});
        alu = op == OP_RTYPE ? fcode :
              op == OP_ADDI  ? ALU_ADD :
              op == OP_ORI   ? ALU_OR  : ALU_AND;
    end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM with memory handshake, wait-state timeout and fault state
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUCTRL_W   = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 memwrite,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 pcen,
    output logic [1:0]           pcsrc,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           zeroext,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 retire,
    output logic                 illegal,
    output logic                 mem_err,
    output logic [3:0]           state_o
);

    state_t          st, nxt;
    logic [TO_W-1:0] cnt;
    logic            err, waiting, timeout, bad_op, bad_funct;
    logic [2:0]      dec_alu;

    mips_alu_decoder #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) u_dec (
        .op(op),
        .funct(funct),
        .alu(dec_alu),
        .bad_op(bad_op),
        .bad_funct(bad_funct)
    );

    // A memory state with ready low on the last allowed cycle falls into FAULT; ready on that cycle still wins.
    assign waiting = st inside {S_FETCH, S_MEMRD, S_MEMWR} && !mem_ready;
    assign timeout = MEM_TIMEOUT != 0 && waiting && cnt == TO_W'(MEM_TIMEOUT - 1);

    always_comb begin
        nxt = st;
        case (st)
            S_FETCH:   nxt = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
            S_DECODE:  nxt = bad_op ? S_FETCH :
                             op inside {OP_LW, OP_SW} ? S_MEMADR :
                             op == OP_RTYPE ? S_RTEXEC :
                             op inside {OP_BEQ, OP_BNE} ? S_BRANCH :
                             op == OP_J ? S_JUMP : S_IMMEXEC;
            S_MEMADR:  nxt = op == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nxt = mem_ready ? S_MEMWB : timeout ? S_FAULT : S_MEMRD;
            S_MEMWR:   nxt = mem_ready ? S_FETCH : timeout ? S_FAULT : S_MEMWR;
            S_RTEXEC:  nxt = bad_funct ? S_FETCH : S_ALUWB;
            S_IMMEXEC: nxt = S_IMMWB;
            S_FAULT:   nxt = S_FAULT;
            default:   nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= S_FETCH;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            st  <= nxt;
            cnt <= nxt != st ? '0 : waiting ? cnt + 1'b1 : cnt;
            err <= err || nxt == S_FAULT;
        end
    end

    always_comb begin
        mem_req    = st inside {S_FETCH, S_MEMRD, S_MEMWR};
        memwrite   = st == S_MEMWR;
        iord       = st inside {S_MEMRD, S_MEMWR};
        irwrite    = st == S_FETCH && mem_ready;
        pcen       = (st == S_FETCH && mem_ready) || st == S_JUMP ||
                     (st == S_BRANCH && (op == OP_BEQ ? zero : !zero));
        pcsrc      = st == S_BRANCH ? PC_ALUOUT : st == S_JUMP ? PC_JUMP : PC_ALU;
        alusrca    = st inside {S_MEMADR, S_RTEXEC, S_BRANCH, S_IMMEXEC};
        alusrcb    = st == S_FETCH ? SRCB_FOUR :
                     st == S_DECODE ? SRCB_IMMSH :
                     st inside {S_MEMADR, S_IMMEXEC} ? SRCB_IMM : SRCB_B;
        zeroext    = st == S_IMMEXEC && op != OP_ADDI ? ZX_ZERO : ZX_SIGN;
        regdst     = st == S_ALUWB;
        memtoreg   = st == S_MEMWB;
        regwrite   = st inside {S_MEMWB, S_ALUWB, S_IMMWB};
        retire     = st inside {S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP} ||
                     (st == S_MEMWR && mem_ready);
        illegal    = (st == S_DECODE && bad_op) || (st == S_RTEXEC && bad_funct);
        alucontrol = ALUCTRL_W'(st inside {S_RTEXEC, S_IMMEXEC} ? dec_alu :
                                st == S_MEMADR ? ALU_ADD :
                                st == S_BRANCH ? ALU_SUB : 3'b000);
    end

    assign mem_err = err;
    assign state_o = st;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: random instruction streams checked against an instruction-level controller model
module tb_mips_mc_controller;
    import mips_pkg::*;

    localparam int TMO = 4;
    localparam logic [17:0] M_REQ  = 18'h20000;
    localparam logic [17:0] M_WR   = 18'h10000;
    localparam logic [17:0] M_IORD = 18'h08000;
    localparam logic [17:0] M_IRW  = 18'h04000;
    localparam logic [17:0] M_PCEN = 18'h02000;
    localparam logic [17:0] M_SRCA = 18'h00400;
    localparam logic [17:0] M_RDST = 18'h00020;
    localparam logic [17:0] M_M2R  = 18'h00010;
    localparam logic [17:0] M_RW   = 18'h00008;
    localparam logic [17:0] M_RET  = 18'h00004;
    localparam logic [17:0] M_ILL  = 18'h00002;

    logic clk = 0, reset = 1, zero = 0, mem_ready = 0;
    logic [5:0] op = 0, funct = 0;
    logic mem_req, memwrite, iord, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, retire, illegal, mem_err;
    logic [1:0] pcsrc, alusrcb, zeroext;
    logic [2:0] alucontrol;
    logic [3:0] state_o;
    logic [17:0] outs;
    int checks = 0, errors = 0;
    logic [5:0] ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                            6'b001000, 6'b001100, 6'b001101, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    mips_mc_controller #(.OP_W(6), .FUNCT_W(6), .ALUCTRL_W(3), .MEM_TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alucontrol(alucontrol), .retire(retire),
        .illegal(illegal), .mem_err(mem_err), .state_o(state_o)
    );

    assign outs = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, zeroext,
                   regdst, memtoreg, regwrite, retire, illegal, 1'b0};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] fld(input logic [1:0] v, input int sh);
        return 18'(v) << sh;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int dly();
        return $urandom_range(0, 9) == 0 ? int'($urandom_range(TMO, TMO + 2)) : int'($urandom_range(0, TMO - 1));
    endfunction

    task automatic cyc(input state_t s, input logic rdy, input logic [17:0] v, input logic [2:0] alu, input bit chk_alu);
        mem_ready = rdy;
        #1;
        check("state", 32'(state_o), 32'(s));
        check($sformatf("outs/%s", s.name()), 32'(outs), 32'(v));
        if (chk_alu) check($sformatf("alucontrol/%s", s.name()), 32'(alucontrol), 32'(alu));
        check("mem_err", 32'(mem_err), 32'(s == S_FAULT));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 0;
        #1;
        check("rst_state", 32'(state_o), 32'(S_FETCH));
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_outs", 32'(outs), 32'(M_REQ | fld(2'b01, 8)));
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic after_fault();
        for (int i = 0; i < 3; i++) cyc(S_FAULT, rb(), 18'd0, 3'b000, 0);
        mem_ready = 0;
        reset_pulse();
    endtask

    // d cycles of ready low, then ready high; running out of wait budget ends in FAULT
    task automatic mem_phase(input state_t s, input int d, input logic [17:0] v, input logic [17:0] vr, output bit flt);
        flt = 0;
        for (int i = 0; i < d; i++) begin
            cyc(s, 1'b0, v, 3'b000, 0);
            if (i == TMO - 1) begin
                flt = 1;
                return;
            end
        end
        cyc(s, 1'b1, v | vr, 3'b000, 0);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int df, input int dm);
        bit flt, ok;
        logic [2:0] a;
        op = o;
        funct = f;
        zero = z;
        mem_phase(S_FETCH, df, M_REQ | fld(2'b01, 8), M_IRW | M_PCEN, flt);
        if (flt) begin
            after_fault();
            return;
        end
        ok = o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b000010};
        cyc(S_DECODE, rb(), fld(2'b11, 8) | (ok ? 18'd0 : M_ILL), 3'b000, 0);
        if (!ok) return;
        if (o == 6'b100011 || o == 6'b101011) begin
            cyc(S_MEMADR, rb(), M_SRCA | fld(2'b10, 8), 3'b010, 1);
            if (o == 6'b100011) begin
                mem_phase(S_MEMRD, dm, M_REQ | M_IORD, 18'd0, flt);
                if (flt) begin
                    after_fault();
                    return;
                end
                cyc(S_MEMWB, rb(), M_RW | M_M2R | M_RET, 3'b000, 0);
            end else begin
                mem_phase(S_MEMWR, dm, M_REQ | M_WR | M_IORD, M_RET, flt);
                if (flt) after_fault();
            end
        end else if (o == 6'b000000) begin
            ok = 1;
            case (f)
                6'b100000: a = 3'b010;
                6'b100010: a = 3'b110;
                6'b100100: a = 3'b000;
                6'b100101: a = 3'b001;
                6'b101010: a = 3'b111;
                default: begin
                    a = 3'b000;
                    ok = 0;
                end
            endcase
            cyc(S_RTEXEC, rb(), M_SRCA | (ok ? 18'd0 : M_ILL), a, ok);
            if (ok) cyc(S_ALUWB, rb(), M_RW | M_RDST | M_RET, 3'b000, 0);
        end else if (o == 6'b000100 || o == 6'b000101) begin
            cyc(S_BRANCH, rb(), M_SRCA | fld(2'b01, 11) | M_RET | ((o == 6'b000100 ? z : !z) ? M_PCEN : 18'd0), 3'b110, 1);
        end else if (o == 6'b000010) begin
            cyc(S_JUMP, rb(), fld(2'b10, 11) | M_PCEN | M_RET, 3'b000, 0);
        end else begin
            a = o == 6'b001000 ? 3'b010 : o == 6'b001100 ? 3'b000 : 3'b001;
            cyc(S_IMMEXEC, rb(), M_SRCA | fld(2'b10, 8) | fld(o == 6'b001000 ? 2'b00 : 2'b01, 6), a, 1);
            cyc(S_IMMWB, rb(), M_RW | M_RET, 3'b000, 0);
        end
    endtask

    initial begin
        #2;
        reset_pulse();
        run_instr(6'b100011, 6'b000000, 1'b0, 3, 1);
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b001101, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, TMO - 1);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, TMO);
        run_instr(6'b000000, 6'b111111, 1'b0, 1, 0);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, TMO, 0);
        for (int n = 0; n < 300; n++) begin
            run_instr($urandom_range(0, 7) == 0 ? 6'($urandom) : ops[$urandom_range(0, 8)],
                      $urandom_range(0, 5) == 0 ? 6'($urandom) : fns[$urandom_range(0, 4)],
                      rb(), dly(), dly());
        end
        op = 6'b100011;
        zero = 0;
        cyc(S_FETCH, 1'b1, M_REQ | fld(2'b01, 8) | M_IRW | M_PCEN, 3'b000, 0);
        cyc(S_DECODE, 1'b0, fld(2'b11, 8), 3'b000, 0);
        cyc(S_MEMADR, 1'b0, M_SRCA | fld(2'b10, 8), 3'b010, 1);
        mem_ready = 0;
        #1;
        check("memrd_before_reset", 32'(state_o), 32'(S_MEMRD));
        reset_pulse();
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
